// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Contents: the FSM state type, the default operand width, and the bit-counter width.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Width of a counter that holds bit indices 0..w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa.sv
// One-bit full adder used as the single arithmetic element of the serial datapath.
// Ports: A, B  - addend bits
//        cin   - carry in
//        sum   - sum bit
//        cout  - carry out
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = A ^ B;
  assign sum  = p ^ cin;
  assign cout = (A & B) | (cin & p);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock through a single full adder.
// Ports: clk, rst_n           - clock, asynchronous active-low reset
//        start_valid/ready    - operation handshake; op_a, op_b, sub are sampled on acceptance
//        res_valid/ready      - result handshake
//        result               - A+B or A-B modulo 2^WIDTH
//        carry                - carry out of the MSB (for subtract, 1 = no borrow)
//        overflow             - two's-complement signed overflow
//        zero                 - result equals 0
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned      CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             fa_sum;
  logic             fa_cout;

  FullAdder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .cin  (cy_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cy_d        = cy_q;
    res_d       = res_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_d     = op_a;
          // Subtract as A + ~B + 1: the +1 enters through the initial carry.
          b_d     = sub ? ~op_b : op_b;
          cy_d    = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = fa_cout;
        res_d = {fa_sum, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // cy_q still holds the carry into the MSB on this edge.
          carry_d = fa_cout;
          ovf_d   = cy_q ^ fa_cout;
          zero_d  = (res_d == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign result   = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int unsigned W       = 32;
  localparam int unsigned LATENCY = 32;
  localparam longint      SMAX    = 64'sd2147483647;
  localparam longint      SMIN    = -64'sd2147483648;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;

  int tests;
  int fails;
  int cyc;
  logic prev_valid;

  exp_t exp_q[$];
  int   acc_q[$];

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry       (carry),
    .overflow    (overflow),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t m;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint sr = s ? (sa - sb) : (sa + sb);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    m.res = s ? (a - b) : (a + b);
    m.c   = s ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
    m.v   = (sr > SMAX) || (sr < SMIN);
    m.z   = (m.res == '0);
    return m;
  endfunction

  // Monitor: pops an expectation whenever a result handshake is about to occur.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= res_valid;
      if (res_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("spurious_res_valid", 64'd1, 64'd0);
        else check("latency", 64'(cyc - acc_q.pop_front()), 64'(LATENCY));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result",   64'(result),   64'(e.res));
          check("carry",    64'(carry),    64'(e.c));
          check("overflow", 64'(overflow), 64'(e.v));
          check("zero",     64'(zero),     64'(e.z));
        end
      end
    end
  end

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation; if hold is set, stall in DONE for 10 cycles with junk on the inputs.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit hold);
    exp_t e;
    bit   got;
    got = 0;
    for (int i = 0; i < 50 && !start_ready; i++) wait_edge();
    if (!start_ready) begin
      check("start_ready_timeout", 64'd0, 64'd1);
      return;
    end
    e           = model(a, b, s);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    sub         = s;
    wait_edge();
    acc_q.push_back(cyc);
    exp_q.push_back(e);
    start_valid = 1'b0;
    op_a        = $urandom;
    op_b        = $urandom;
    sub         = 1'($urandom);
    if (hold) begin
      res_ready = 1'b0;
      for (int i = 0; i < 100 && !res_valid; i++) wait_edge();
      check("hold_reach_done", 64'(res_valid), 64'd1);
      for (int k = 0; k < 10; k++) begin
        start_valid = 1'($urandom);
        op_a        = $urandom;
        op_b        = $urandom;
        sub         = 1'($urandom);
        wait_edge();
        check("hold_result",      64'(result),      64'(e.res));
        check("hold_carry",       64'(carry),       64'(e.c));
        check("hold_res_valid",   64'(res_valid),   64'd1);
        check("hold_start_ready", 64'(start_ready), 64'd0);
      end
      // start_valid stays high across the handshake edge and must be ignored.
      start_valid = 1'b1;
      res_ready   = 1'b1;
      wait_edge();
      start_valid = 1'b0;
      check("release_start_ready", 64'(start_ready), 64'd1);
      check("release_res_valid",   64'(res_valid),   64'd0);
      check("idle_keeps_result",   64'(result),      64'(e.res));
      return;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if (res_valid && res_ready) got = 1;
      wait_edge();
    end
    if (!got) check("res_valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;
    res_ready   = 1'b1;
    #3;
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_res_valid",   64'(res_valid),   64'd0);
    check("rst_result",      64'(result),      64'd0);
    check("rst_flags",       64'({carry, overflow, zero}), 64'd0);
    wait_edge();
    rst_n = 1'b1;

    run_op(32'd5,          32'd7,          1'b0, 0);
    run_op(32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 0);
    run_op(32'h7FFF_FFFF,  32'h0000_0001,  1'b0, 0);
    run_op(32'd3,          32'd5,          1'b1, 0);
    run_op(32'd5,          32'd5,          1'b1, 0);
    run_op(32'h8000_0000,  32'h0000_0001,  1'b1, 0);
    run_op(32'h8000_0000,  32'h8000_0000,  1'b0, 0);
    run_op(32'h0000_0000,  32'h0000_0000,  1'b1, 0);

    run_op(32'h1234_5678,  32'h0FED_CBA9,  1'b1, 1);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'h7FFF_FFFF;
        2: rb = ra;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), 0);
    end

    // Abort mid-operation: reset acts immediately, the in-flight result is dropped.
    start_valid = 1'b1;
    op_a        = 32'hDEAD_BEEF;
    op_b        = 32'h0000_1111;
    sub         = 1'b0;
    wait_edge();
    start_valid = 1'b0;
    repeat (10) wait_edge();
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_res_valid",   64'(res_valid),   64'd0);
    check("abort_start_ready", 64'(start_ready), 64'd1);
    check("abort_result",      64'(result),      64'd0);
    wait_edge();
    rst_n = 1'b1;
    res_ready = 1'b1;
    run_op(32'd1, 32'd1, 1'b0, 0);
    e = model(32'd1, 32'd1, 1'b0);
    check("after_reset_result", 64'(result), 64'(e.res));

    repeat (3) wait_edge();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Reset path: drop any expectations of the aborted operation.
  always @(negedge rst_n) begin
    exp_q.delete();
    acc_q.delete();
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
